// File: rtl/mem_arbiter.sv
// Two-master Wishbone pipelined arbiter in front of one shared memory slave.
// Grant after one IDLE cycle, per-grant outstanding limit, hold-time preemption through DRAIN.
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MAX_HOLD        = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_wb_cyc,
  input  logic        i_m0_wb_stb,
  input  logic        i_m0_wb_we,
  input  logic [31:0] i_m0_wb_addr,
  input  logic [31:0] i_m0_wb_data,
  input  logic [3:0]  i_m0_wb_sel,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_stall,
  output logic [31:0] o_m0_wb_data,
  input  logic        i_m1_wb_cyc,
  input  logic        i_m1_wb_stb,
  input  logic        i_m1_wb_we,
  input  logic [31:0] i_m1_wb_addr,
  input  logic [31:0] i_m1_wb_data,
  input  logic [3:0]  i_m1_wb_sel,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_stall,
  output logic [31:0] o_m1_wb_data,
  output logic        o_s_wb_cyc,
  output logic        o_s_wb_stb,
  output logic        o_s_wb_we,
  output logic [31:0] o_s_wb_addr,
  output logic [31:0] o_s_wb_data,
  output logic [3:0]  o_s_wb_sel,
  input  logic        i_s_wb_ack,
  input  logic        i_s_wb_stall,
  input  logic [31:0] i_s_wb_data,
  output logic [1:0]  o_grant
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DRAIN} state_t;

  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam int          HOLD_I   = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [15:0] HOLD_LIM = 16'(HOLD_I);

  state_t      r_state;
  logic        r_holder;
  logic        r_last;
  logic [3:0]  r_cnt;
  logic [15:0] r_hold;
  logic [1:0]  r_grant;

  logic        w_active, w_granting;
  logic        w_h_cyc, w_h_stb, w_o_cyc;
  logic        w_full, w_inc, w_dec;
  logic        w_h_ack, w_h_stall;

  assign w_active   = (r_state != IDLE);
  assign w_granting = (r_state == GRANT0) || (r_state == GRANT1);
  assign w_h_cyc    = r_holder ? i_m1_wb_cyc : i_m0_wb_cyc;
  assign w_h_stb    = r_holder ? i_m1_wb_stb : i_m0_wb_stb;
  assign w_o_cyc    = r_holder ? i_m0_wb_cyc : i_m1_wb_cyc;
  assign w_full     = (r_cnt == MAX_OUT);

  assign o_s_wb_cyc  = w_active & w_h_cyc;
  assign o_s_wb_stb  = w_granting & w_h_cyc & w_h_stb & ~w_full;
  assign o_s_wb_we   = w_active & (r_holder ? i_m1_wb_we : i_m0_wb_we);
  assign o_s_wb_addr = w_active ? (r_holder ? i_m1_wb_addr : i_m0_wb_addr) : 32'h0;
  assign o_s_wb_data = w_active ? (r_holder ? i_m1_wb_data : i_m0_wb_data) : 32'h0;
  assign o_s_wb_sel  = w_active ? (r_holder ? i_m1_wb_sel : i_m0_wb_sel) : 4'h0;

  // Acks with nothing in flight are swallowed so the counter cannot underflow.
  assign w_h_ack   = w_active & i_s_wb_ack & (r_cnt != 4'd0);
  assign w_h_stall = ~w_granting | i_s_wb_stall | w_full;
  assign w_inc     = o_s_wb_stb & ~i_s_wb_stall;
  assign w_dec     = w_h_ack;

  assign o_m0_wb_ack   = w_h_ack & ~r_holder;
  assign o_m0_wb_stall = ~(w_active & ~r_holder) | w_h_stall;
  assign o_m0_wb_data  = (w_active & ~r_holder) ? i_s_wb_data : 32'h0;
  assign o_m1_wb_ack   = w_h_ack & r_holder;
  assign o_m1_wb_stall = ~(w_active & r_holder) | w_h_stall;
  assign o_m1_wb_data  = (w_active & r_holder) ? i_s_wb_data : 32'h0;
  assign o_grant       = r_grant;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_holder <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= 4'd0;
      r_hold   <= 16'd0;
      r_grant  <= 2'b00;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + 4'd1;
        2'b01:   r_cnt <= r_cnt - 4'd1;
        default: r_cnt <= r_cnt;
      endcase
      case (r_state)
        IDLE: begin
          r_cnt  <= 4'd0;
          r_hold <= 16'd0;
          // On a tie the master that was not served last wins.
          if (i_m0_wb_cyc && (!i_m1_wb_cyc || r_last)) begin
            r_state  <= GRANT0;
            r_holder <= 1'b0;
            r_last   <= 1'b0;
            r_grant  <= 2'b01;
          end else if (i_m1_wb_cyc) begin
            r_state  <= GRANT1;
            r_holder <= 1'b1;
            r_last   <= 1'b1;
            r_grant  <= 2'b10;
          end
        end
        GRANT0, GRANT1: begin
          if (!w_h_cyc) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_grant <= 2'b00;
          end else begin
            if (r_hold != 16'hFFFF) r_hold <= r_hold + 16'd1;
            // Preempt at the end of the MAX_HOLD-th grant cycle if the other side waits.
            if (MAX_HOLD != 0 && r_hold >= HOLD_LIM && w_o_cyc) r_state <= DRAIN;
          end
        end
        default: begin
          if (!w_h_cyc || r_cnt == 4'd0) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_grant <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant, tie-break, outstanding limit, preemption, reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m0_stall, m1_ack, m1_stall;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we, s_ack, s_stall;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(4), .MAX_HOLD(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .i_m0_wb_we(m0_we),
    .i_m0_wb_addr(m0_addr), .i_m0_wb_data(m0_wdata), .i_m0_wb_sel(m0_sel),
    .o_m0_wb_ack(m0_ack), .o_m0_wb_stall(m0_stall), .o_m0_wb_data(m0_rdata),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .i_m1_wb_we(m1_we),
    .i_m1_wb_addr(m1_addr), .i_m1_wb_data(m1_wdata), .i_m1_wb_sel(m1_sel),
    .o_m1_wb_ack(m1_ack), .o_m1_wb_stall(m1_stall), .o_m1_wb_data(m1_rdata),
    .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb), .o_s_wb_we(s_we),
    .o_s_wb_addr(s_addr), .o_s_wb_data(s_wdata), .o_s_wb_sel(s_sel),
    .i_s_wb_ack(s_ack), .i_s_wb_stall(s_stall), .i_s_wb_data(s_rdata),
    .o_grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_sel = 0;
    s_ack = 0; s_stall = 0; s_rdata = 0;
    #12;
    check("rst_grant", grant, 0);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_m0_stall", m0_stall, 1);
    check("rst_m1_stall", m1_stall, 1);
    check("rst_m0_ack", m0_ack, 0);
    tick;
    rst_n = 1'b1;

    // Single read from m0
    m0_cyc = 1; m0_stb = 1; m0_addr = 32'h0000_0100; m0_sel = 4'hF;
    @(negedge clk); check("rd_idle_cyc", s_cyc, 0);
    tick;
    @(negedge clk);
    check("rd_s_cyc", s_cyc, 1);
    check("rd_grant", grant, 2'b01);
    check("rd_s_stb", s_stb, 1);
    check("rd_s_addr", s_addr, 32'h0000_0100);
    check("rd_s_sel", s_sel, 4'hF);
    check("rd_m0_stall", m0_stall, 0);
    check("rd_m1_stall", m1_stall, 1);
    tick;
    m0_stb = 0;
    @(negedge clk); check("rd_stb_low", s_stb, 0);
    tick;
    s_ack = 1; s_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("rd_m0_ack", m0_ack, 1);
    check("rd_m0_data", m0_rdata, 32'hDEADBEEF);
    check("rd_m1_ack", m1_ack, 0);
    check("rd_m1_data", m1_rdata, 0);
    tick;
    s_ack = 0;
    @(negedge clk); check("rd_ack_done", m0_ack, 0);
    m0_cyc = 0;
    @(negedge clk); check("rd_drop_cyc", s_cyc, 0);
    tick;
    @(negedge clk); check("rd_idle_grant", grant, 0);

    // Spurious ack while idle
    s_ack = 1; s_rdata = 32'h0000_1234;
    @(negedge clk);
    check("idle_ack", m0_ack, 0);
    check("idle_data", m0_rdata, 0);
    tick;
    s_ack = 0;

    // Tie straight after reset goes to m0, then m1 after one idle cycle
    rst_n = 0; #2; rst_n = 1;
    m0_cyc = 1; m1_cyc = 1;
    tick;
    @(negedge clk);
    check("tie_grant0", grant, 2'b01);
    check("tie_m1_stall", m1_stall, 1);
    s_ack = 1;
    @(negedge clk); check("cnt0_ack", m0_ack, 0);
    tick;
    s_ack = 0;
    m0_cyc = 0;
    @(negedge clk); check("tie_drop", s_cyc, 0);
    tick;
    @(negedge clk); check("tie_idle", grant, 0);
    tick;
    @(negedge clk);
    check("tie_grant1", grant, 2'b10);
    check("tie_s_cyc", s_cyc, 1);
    check("tie_m1_go", m1_stall, 0);
    check("tie_m0_stall", m0_stall, 1);
    m1_cyc = 0;
    tick;

    // Outstanding limit of 4 with a silent slave
    m0_cyc = 1; m0_stb = 1;
    tick;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lim_accept_stb", s_stb, 1);
      check("lim_accept_stall", m0_stall, 0);
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("lim_full_stb", s_stb, 0);
      check("lim_full_stall", m0_stall, 1);
      tick;
    end
    s_ack = 1;
    @(negedge clk);
    check("lim_ack", m0_ack, 1);
    check("lim_ack_stb", s_stb, 0);
    tick;
    s_ack = 0;
    @(negedge clk);
    check("lim_reopen_stb", s_stb, 1);
    check("lim_reopen_stall", m0_stall, 0);
    tick;
    @(negedge clk); check("lim_refull", s_stb, 0);
    m0_cyc = 0; m0_stb = 0;
    tick;
    s_ack = 1;
    @(negedge clk); check("late_ack", m0_ack, 0);
    tick;
    s_ack = 0;

    // Preemption after 16 grant cycles
    m0_cyc = 1; m0_stb = 1;
    tick;
    m1_cyc = 1; s_ack = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("hold_grant", grant, 2'b01);
      check("hold_stb", s_stb, 1);
      tick;
    end
    @(negedge clk);
    check("drain_stb", s_stb, 0);
    check("drain_stall", m0_stall, 1);
    check("drain_cyc", s_cyc, 1);
    check("drain_ack", m0_ack, 1);
    tick;
    s_ack = 0;
    @(negedge clk);
    check("drain2_grant", grant, 2'b01);
    check("drain2_stb", s_stb, 0);
    tick;
    @(negedge clk);
    check("drain_idle", grant, 0);
    check("drain_idle_cyc", s_cyc, 0);
    tick;
    @(negedge clk);
    check("drain_grant1", grant, 2'b10);
    check("drain_m0_stall", m0_stall, 1);

    // Asynchronous reset with two requests in flight
    m0_cyc = 0; m0_stb = 0; m1_stb = 1;
    tick;
    tick;
    m1_stb = 0;
    #2;
    rst_n = 0; s_ack = 1; s_rdata = 32'h5555_AAAA;
    #1;
    check("arst_grant", grant, 0);
    check("arst_s_cyc", s_cyc, 0);
    check("arst_s_addr", s_addr, 0);
    check("arst_m1_stall", m1_stall, 1);
    check("arst_m1_ack", m1_ack, 0);
    check("arst_m1_data", m1_rdata, 0);
    tick;
    rst_n = 1;
    @(negedge clk); check("post_rst_idle_ack", m1_ack, 0);
    tick;
    @(negedge clk);
    check("post_rst_grant", grant, 2'b10);
    check("post_rst_ack", m1_ack, 0);
    tick;
    s_ack = 0; m1_cyc = 0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
